// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, limits and state codes for the PWM sequencer
package pwm_pkg;

  localparam int DutyWidth = 7;
  localparam logic [DutyWidth-1:0] DutyMax = 7'd100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    FAULT = 3'd3
  } state_e;

endpackage

// File: rtl/duty_ramp.sv
// rtl/duty_ramp.sv - per-channel target/duty registers with saturating step-toward logic
module duty_ramp #(
  parameter int Width = 7,
  parameter int Step  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_en_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             step_en_i,
  input  logic             track_en_i,
  output logic [Width-1:0] duty_o,
  output logic             at_target_o
);

  logic [Width-1:0] target_q, target_d;
  logic [Width-1:0] duty_q, duty_d;
  logic [Width-1:0] stepped;
  logic [Width:0]   gap, gap_lim;
  logic             going_up;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= '0;
      duty_q   <= '0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
    end
  end

  // Steps aim at the target that will hold after this edge, so a reload
  // on the same sync is honoured immediately.
  always_comb begin
    target_d = load_en_i ? load_val_i : target_q;
    going_up = (target_d >= duty_q);
    gap      = going_up ? ({1'b0, target_d} - {1'b0, duty_q})
                        : ({1'b0, duty_q} - {1'b0, target_d});
    gap_lim  = (gap > (Width+1)'(Step)) ? (Width+1)'(Step) : gap;
    stepped  = going_up ? Width'({1'b0, duty_q} + gap_lim)
                        : Width'({1'b0, duty_q} - gap_lim);
    // True when the step taken on this edge lands exactly on the target.
    at_target_o = (stepped == target_d);

    duty_d = duty_q;
    if (clear_i) begin
      duty_d = '0;
    end else if (track_en_i) begin
      duty_d = target_d;
    end else if (step_en_i) begin
      duty_d = stepped;
    end
  end

  assign duty_o = duty_q;

endmodule

// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - start-up/run/shutdown sequencer feeding the two-channel PWM core
module pwm_sequencer #(
  parameter int                   DutyWidth = pwm_pkg::DutyWidth,
  parameter logic [DutyWidth-1:0] DutyMax   = pwm_pkg::DutyMax,
  parameter int                   RampStep  = 1,
  parameter int                   RampDiv   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 fault_i,
  input  logic                 fault_clr_i,
  input  logic                 sync_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DutyWidth-1:0] cmd_d1_i,
  input  logic [DutyWidth-1:0] cmd_d2_i,
  output logic [DutyWidth-1:0] duty_d1_o,
  output logic [DutyWidth-1:0] duty_d2_o,
  output logic                 pwm_en_o,
  output logic                 fault_o,
  output logic [2:0]           state_o
);

  import pwm_pkg::*;

  localparam int CntW = (RampDiv > 1) ? $clog2(RampDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RampDiv - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DutyWidth-1:0] shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic                 pending_q, pending_d;
  logic                 xfer, load_en, step_en, track_en, clear;
  logic                 at1, at2;

  function automatic logic [DutyWidth-1:0] sat(input logic [DutyWidth-1:0] v);
    return (v > DutyMax) ? DutyMax : v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow1_q <= '0;
      shadow2_q <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow1_q <= shadow1_d;
      shadow2_q <= shadow2_d;
      pending_q <= pending_d;
    end
  end

  // Setpoint handshake: a transfer in a sync cycle is not loaded on that
  // sync because pending is still low; it waits for the following one.
  always_comb begin
    cmd_ready_o = ((state_q == RAMP) || (state_q == RUN)) && !pending_q;
    xfer        = cmd_valid_i && cmd_ready_o;
    load_en     = sync_i && pending_q;
    pending_d   = pending_q;
    shadow1_d   = shadow1_q;
    shadow2_d   = shadow2_q;
    if (load_en) begin
      pending_d = 1'b0;
    end else if (xfer) begin
      pending_d = 1'b1;
      shadow1_d = sat(cmd_d1_i);
      shadow2_d = sat(cmd_d2_i);
    end
  end

  always_comb begin
    step_en = (state_q == RAMP) && sync_i && (cnt_q == CntLast);
    cnt_d   = cnt_q;
    if (state_q != RAMP) begin
      cnt_d = '0;
    end else if (sync_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fault_i)                   state_d = FAULT;
        else if (sync_i && enable_i)   state_d = RAMP;
      end
      RAMP: begin
        if (fault_i)                   state_d = FAULT;
        else if (!enable_i)            state_d = IDLE;
        else if (step_en && at1 && at2) state_d = RUN;
      end
      RUN: begin
        if (fault_i)                   state_d = FAULT;
        else if (!enable_i)            state_d = IDLE;
      end
      FAULT: begin
        if (fault_clr_i && !fault_i && !enable_i) state_d = IDLE;
      end
      default:                         state_d = FAULT;
    endcase
    clear    = !((state_d == RAMP) || (state_d == RUN));
    track_en = (state_q == RUN) && sync_i;
  end

  duty_ramp #(.Width(DutyWidth), .Step(RampStep)) u_ramp_d1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .load_en_i   (load_en),
    .load_val_i  (shadow1_q),
    .step_en_i   (step_en),
    .track_en_i  (track_en),
    .duty_o      (duty_d1_o),
    .at_target_o (at1)
  );

  duty_ramp #(.Width(DutyWidth), .Step(RampStep)) u_ramp_d2 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear),
    .load_en_i   (load_en),
    .load_val_i  (shadow2_q),
    .step_en_i   (step_en),
    .track_en_i  (track_en),
    .duty_o      (duty_d2_o),
    .at_target_o (at2)
  );

  assign pwm_en_o = (state_q == RAMP) || (state_q == RUN);
  assign fault_o  = (state_q == FAULT);
  assign state_o  = state_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb/tb_pwm_sequencer.sv - scoreboard bench for pwm_sequencer
module tb_pwm_sequencer;

  localparam int RDIV = 4;
  localparam int DMAX = 100;

  logic       clk = 1'b0;
  logic       rst, enable, fault, fault_clr, sync, cmd_valid, cmd_ready;
  logic [6:0] cmd_d1, cmd_d2, duty_d1, duty_d2;
  logic       pwm_en, fault_o;
  logic [2:0] state;

  always #5 clk = ~clk;

  pwm_sequencer dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .fault_i     (fault),
    .fault_clr_i (fault_clr),
    .sync_i      (sync),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_d1_i    (cmd_d1),
    .cmd_d2_i    (cmd_d2),
    .duty_d1_o   (duty_d1),
    .duty_d2_o   (duty_d2),
    .pwm_en_o    (pwm_en),
    .fault_o     (fault_o),
    .state_o     (state)
  );

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  int m_st, m_d1, m_d2, m_t1, m_t2, m_s1, m_s2, m_pend, m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int toward(input int d, input int t);
    if (d < t) return d + 1;
    if (d > t) return d - 1;
    return d;
  endfunction

  function automatic int satv(input int v);
    return (v > DMAX) ? DMAX : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_d1 = 0; m_d2 = 0; m_t1 = 0; m_t2 = 0;
    m_s1 = 0; m_s2 = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic tick(input logic s);
    int ns, nd1, nd2, nt1, nt2, ns1, ns2, npend, ncnt;
    bit rdy, xfer, step, at, nrdy;
    logic [19:0] e, got;
    sync  = s;
    rdy   = (m_st == 1 || m_st == 2) && (m_pend == 0);
    xfer  = cmd_valid && rdy;
    nt1   = (s && m_pend != 0) ? m_s1 : m_t1;
    nt2   = (s && m_pend != 0) ? m_s2 : m_t2;
    ns1   = m_s1; ns2 = m_s2; npend = m_pend;
    if (s && m_pend != 0) npend = 0;
    else if (xfer) begin
      npend = 1; ns1 = satv(int'(cmd_d1)); ns2 = satv(int'(cmd_d2));
    end
    step = (m_st == 1) && s && (m_cnt == RDIV - 1);
    at   = (toward(m_d1, nt1) == nt1) && (toward(m_d2, nt2) == nt2);
    case (m_st)
      0: ns = fault ? 3 : (s && enable) ? 1 : 0;
      1: ns = fault ? 3 : !enable ? 0 : (step && at) ? 2 : 1;
      2: ns = fault ? 3 : !enable ? 0 : 2;
      default: ns = (fault_clr && !fault && !enable) ? 0 : 3;
    endcase
    if (ns != 1 && ns != 2) begin nd1 = 0; nd2 = 0; end
    else if (m_st == 2 && s) begin nd1 = nt1; nd2 = nt2; end
    else if (step) begin nd1 = toward(m_d1, nt1); nd2 = toward(m_d2, nt2); end
    else begin nd1 = m_d1; nd2 = m_d2; end
    ncnt = (m_st != 1) ? 0 : s ? ((m_cnt == RDIV - 1) ? 0 : m_cnt + 1) : m_cnt;
    nrdy = (ns == 1 || ns == 2) && (npend == 0);
    e = {3'(ns), 7'(nd1), 7'(nd2), (ns == 1 || ns == 2), (ns == 3), nrdy};
    exp_q.push_back(e);
    m_st = ns; m_d1 = nd1; m_d2 = nd2; m_t1 = nt1; m_t2 = nt2;
    m_s1 = ns1; m_s2 = ns2; m_pend = npend; m_cnt = ncnt;
    @(posedge clk);
    #1;
    got = {state, duty_d1, duty_d2, pwm_en, fault_o, cmd_ready};
    check_eq("cycle", got, exp_q.pop_front());
    sync = 1'b0; cmd_valid = 1'b0; fault_clr = 1'b0;
  endtask

  task automatic period();
    tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1);
  endtask

  task automatic send(input int a, input int b, input logic s);
    check_eq("cmd_ready_before_send", cmd_ready, 1);
    cmd_d1 = 7'(a); cmd_d2 = 7'(b); cmd_valid = 1'b1;
    tick(s);
  endtask

  initial begin
    int hold_d1;
    rst = 1'b1; enable = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    sync = 1'b0; cmd_valid = 1'b0; cmd_d1 = '0; cmd_d2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, 0);
    check_eq("rst_duty1", duty_d1, 0);
    check_eq("rst_duty2", duty_d2, 0);
    check_eq("rst_pwm_en", pwm_en, 0);
    check_eq("rst_fault", fault_o, 0);
    check_eq("rst_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // soft start to 40/60
    enable = 1'b1;
    period();
    check_eq("t1_pwm_en_first_sync", pwm_en, 1);
    check_eq("t1_state_ramp", state, 1);
    send(40, 60, 1'b0);
    hold_d1 = -1;
    for (int i = 0; i < 400 && state != 3'd2; i++) begin
      period();
      if (duty_d2 == 7'd50 && hold_d1 < 0) hold_d1 = int'(duty_d1);
    end
    check_eq("t1_state_run", state, 2);
    check_eq("t1_d1_held_while_d2_ramps", hold_d1, 40);
    check_eq("t1_d1_final", duty_d1, 40);
    check_eq("t1_d2_final", duty_d2, 60);

    // step change in RUN, command 3 cycles before sync
    send(90, 20, 1'b0);
    check_eq("t2_ready_low", cmd_ready, 0);
    tick(1'b0); tick(1'b0);
    check_eq("t2_d1_hold", duty_d1, 40);
    tick(1'b1);
    check_eq("t2_d1_new", duty_d1, 90);
    check_eq("t2_d2_new", duty_d2, 20);
    check_eq("t2_ready_back", cmd_ready, 1);

    // saturation, and transfer coinciding with sync
    send(127, 127, 1'b1);
    check_eq("t3_not_applied_d1", duty_d1, 90);
    period();
    check_eq("t3_sat_d1", duty_d1, 100);
    check_eq("t3_sat_d2", duty_d2, 100);

    // disable in RUN
    enable = 1'b0;
    tick(1'b0);
    check_eq("t5_idle", state, 0);
    check_eq("t5_duty_zero", duty_d1, 0);

    // fault mid-ramp
    enable = 1'b1;
    period();
    repeat (5) period();
    check_eq("t4_ramping_d1", duty_d1, 1);
    tick(1'b0);
    fault = 1'b1;
    tick(1'b0);
    fault = 1'b0;
    check_eq("t4_fault_state", state, 3);
    check_eq("t4_fault_o", fault_o, 1);
    check_eq("t4_pwm_off", pwm_en, 0);
    check_eq("t4_duty_zero", duty_d2, 0);
    fault_clr = 1'b1;
    tick(1'b0);
    check_eq("t4_clr_ignored", state, 3);
    enable = 1'b0;
    fault_clr = 1'b1;
    tick(1'b0);
    check_eq("t4_clr_idle", state, 0);
    check_eq("t4_fault_cleared", fault_o, 0);

    // asynchronous reset mid-ramp
    enable = 1'b1;
    period();
    repeat (6) period();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_arst_pwm_en", pwm_en, 0);
    check_eq("t5_arst_duty", duty_d1, 0);
    check_eq("t5_arst_state", state, 0);
    model_reset();
    rst = 1'b0;

    // target lowered below current duty mid-ramp
    period();
    send(100, 100, 1'b0);
    repeat (48) period();
    check_eq("t6_ramped_up", (duty_d1 > 7'd5) ? 1 : 0, 1);
    send(5, 0, 1'b0);
    for (int i = 0; i < 200 && state != 3'd2; i++) period();
    check_eq("t6_state_run", state, 2);
    check_eq("t6_d1", duty_d1, 5);
    check_eq("t6_d2", duty_d2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
